// File: rtl/game_sequencer.sv
// game_sequencer: dino-runner game controller (STARTING/PLAYING/HIT sequencing, obstacle spawns,
// collision detection, score pacing). Define GAME_SEQ_GODMODE_EN to compile out the collision path.
module game_sequencer #(
    parameter int MIN_GAP   = 40,
    parameter int SCORE_DIV = 6,
    parameter int HIT_HOLD  = 60
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        next_frame_i,
    input  logic        visible_i,
    input  logic        dino_pixel_i,
    input  logic        bird_pixel_i,
    input  logic        cactus_pixel_i,
    input  logic [15:0] rand_i,
    output logic [1:0]  state_o,
    output logic        lfsr_next_o,
    output logic        score_en_o,
    output logic        bird_spawn_o,
    output logic        cactus_spawn_o,
    output logic        hit_o,
    output logic        title_en_o,
    output logic        round_rst_no
);

    localparam logic [1:0] ST_STARTING = 2'd0;
    localparam logic [1:0] ST_PLAYING  = 2'd1;
    localparam logic [1:0] ST_HIT      = 2'd2;

    localparam logic [7:0] LP_MIN_GAP  = MIN_GAP[7:0];
    localparam logic [7:0] LP_DIV_LAST = 8'(SCORE_DIV - 1);
    localparam logic [7:0] LP_HIT_HOLD = HIT_HOLD[7:0];

    generate
        if (MIN_GAP < 1 || MIN_GAP > 255) begin : g_bad_min_gap
            $error("game_sequencer: MIN_GAP must be within 1..255");
        end
        if (SCORE_DIV < 1 || SCORE_DIV > 255) begin : g_bad_score_div
            $error("game_sequencer: SCORE_DIV must be within 1..255");
        end
        if (HIT_HOLD < 0 || HIT_HOLD > 255) begin : g_bad_hit_hold
            $error("game_sequencer: HIT_HOLD must be within 0..255");
        end
    endgenerate

    logic [1:0] r_state;
    logic       r_start_q;
    logic [7:0] r_gap;
    logic [7:0] r_div;
    logic [7:0] r_hold;
    logic       r_hit_pend;
    logic       r_lfsr;
    logic       r_score;
    logic       r_bird;
    logic       r_cactus;
    logic       r_hit;
    logic       r_title;
    logic       r_round_rst_n;

    logic [1:0] w_state_nxt;
    logic [7:0] w_gap_nxt;
    logic [7:0] w_div_nxt;
    logic [7:0] w_hold_nxt;
    logic       w_pend_nxt;
    logic       w_lfsr_nxt;
    logic       w_score_nxt;
    logic       w_bird_nxt;
    logic       w_cactus_nxt;
    logic       w_hit_nxt;
    logic       w_title_nxt;
    logic       w_round_rst_n_nxt;

    logic w_start_rise;
    logic w_overlap;
    logic w_collide;
    logic w_frame_ok;
    logic w_gap_full;
    logic w_hold_full;
    logic w_rand_cactus;
    logic w_rand_bird;
    logic w_spawn;
    logic w_unused;

    assign w_start_rise  = start_i & ~r_start_q;
    assign w_gap_full    = (r_gap == LP_MIN_GAP);
    assign w_hold_full   = (r_hold == LP_HIT_HOLD);
    assign w_rand_cactus = (rand_i[12:7] == 6'b101010);
    assign w_rand_bird   = (rand_i[12:8] == 5'b00000);
    assign w_spawn       = w_gap_full & (w_rand_cactus | w_rand_bird);

`ifdef GAME_SEQ_GODMODE_EN
    assign w_overlap = 1'b0;
    assign w_unused  = ^{rand_i[15:13], rand_i[6:0], visible_i, dino_pixel_i,
                         bird_pixel_i, cactus_pixel_i};
`else
    assign w_overlap = visible_i & dino_pixel_i & (bird_pixel_i | cactus_pixel_i);
    assign w_unused  = ^{rand_i[15:13], rand_i[6:0]};
`endif

    // A frame ends the round if an overlap was seen at any point in it, including its last cycle.
    assign w_collide  = next_frame_i & (r_hit_pend | w_overlap);
    assign w_frame_ok = (r_state == ST_PLAYING) & next_frame_i & ~w_collide;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_STARTING;
            r_start_q     <= 1'b1;
            r_gap         <= 8'd0;
            r_div         <= 8'd0;
            r_hold        <= 8'd0;
            r_hit_pend    <= 1'b0;
            r_lfsr        <= 1'b0;
            r_score       <= 1'b0;
            r_bird        <= 1'b0;
            r_cactus      <= 1'b0;
            r_hit         <= 1'b0;
            r_title       <= 1'b1;
            r_round_rst_n <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_start_q     <= start_i;
            r_gap         <= w_gap_nxt;
            r_div         <= w_div_nxt;
            r_hold        <= w_hold_nxt;
            r_hit_pend    <= w_pend_nxt;
            r_lfsr        <= w_lfsr_nxt;
            r_score       <= w_score_nxt;
            r_bird        <= w_bird_nxt;
            r_cactus      <= w_cactus_nxt;
            r_hit         <= w_hit_nxt;
            r_title       <= w_title_nxt;
            r_round_rst_n <= w_round_rst_n_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gap_nxt   = r_gap;
        w_div_nxt   = r_div;
        w_hold_nxt  = r_hold;
        w_pend_nxt  = 1'b0;
        case (r_state)
            ST_STARTING: begin
                if (w_start_rise) begin
                    w_state_nxt = ST_PLAYING;
                    w_gap_nxt   = 8'd0;
                    w_div_nxt   = 8'd0;
                    w_hold_nxt  = 8'd0;
                end
            end
            ST_PLAYING: begin
                if (next_frame_i) begin
                    if (w_collide) begin
                        w_state_nxt = ST_HIT;
                    end else begin
                        w_div_nxt = (r_div == LP_DIV_LAST) ? 8'd0 : r_div + 8'd1;
                        if (!w_gap_full) begin
                            w_gap_nxt = r_gap + 8'd1;
                        end else if (w_spawn) begin
                            w_gap_nxt = 8'd0;
                        end
                    end
                end else begin
                    w_pend_nxt = r_hit_pend | w_overlap;
                end
            end
            ST_HIT: begin
                // The rise is judged against the hold value before this cycle's frame update.
                if (w_start_rise && w_hold_full) begin
                    w_state_nxt = ST_STARTING;
                end else if (next_frame_i && !w_hold_full) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_STARTING;
            end
        endcase
    end

    always_comb begin
        w_lfsr_nxt        = (w_state_nxt == ST_STARTING) | w_frame_ok;
        w_score_nxt       = w_frame_ok & (r_div == LP_DIV_LAST);
        w_cactus_nxt      = w_frame_ok & w_gap_full & w_rand_cactus;
        w_bird_nxt        = w_frame_ok & w_gap_full & ~w_rand_cactus & w_rand_bird;
        w_title_nxt       = (w_state_nxt == ST_STARTING);
        w_round_rst_n_nxt = ~((r_state == ST_STARTING) & w_start_rise);
`ifdef GAME_SEQ_GODMODE_EN
        w_hit_nxt         = 1'b0;
`else
        w_hit_nxt         = (w_state_nxt == ST_HIT);
`endif
    end

    assign state_o        = r_state;
    assign lfsr_next_o    = r_lfsr;
    assign score_en_o     = r_score;
    assign bird_spawn_o   = r_bird;
    assign cactus_spawn_o = r_cactus;
    assign hit_o          = r_hit;
    assign title_en_o     = r_title;
    assign round_rst_no   = r_round_rst_n;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a frame-level game model predicts pulses and levels.
`timescale 1ns/1ps
module tb_game_sequencer;

    localparam int MIN_GAP   = 40;
    localparam int SCORE_DIV = 6;
    localparam int HIT_HOLD  = 60;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b1;
    logic        next_frame_i = 1'b0;
    logic        visible_i = 1'b0;
    logic        dino_pixel_i = 1'b0;
    logic        bird_pixel_i = 1'b0;
    logic        cactus_pixel_i = 1'b0;
    logic [15:0] rand_i = 16'h0000;
    logic [1:0]  state_o;
    logic        lfsr_next_o, score_en_o, bird_spawn_o, cactus_spawn_o;
    logic        hit_o, title_en_o, round_rst_no;

    always #5 clk_i = ~clk_i;

    game_sequencer #(.MIN_GAP(MIN_GAP), .SCORE_DIV(SCORE_DIV), .HIT_HOLD(HIT_HOLD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .next_frame_i(next_frame_i),
        .visible_i(visible_i), .dino_pixel_i(dino_pixel_i), .bird_pixel_i(bird_pixel_i),
        .cactus_pixel_i(cactus_pixel_i), .rand_i(rand_i), .state_o(state_o),
        .lfsr_next_o(lfsr_next_o), .score_en_o(score_en_o), .bird_spawn_o(bird_spawn_o),
        .cactus_spawn_o(cactus_spawn_o), .hit_o(hit_o), .title_en_o(title_en_o),
        .round_rst_no(round_rst_no)
    );

    typedef struct packed { int due; logic sc; logic bd; logic ct; logic lf; } ev_t;
    ev_t exp_q[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0, fr = 0;
    bit mon_en = 1'b0;
    bit st_lvl = 1'b1;
    int n_score = 0, n_bird = 0, n_cact = 0;
    int cact_frames[$];

    logic [1:0] e_state = 2'd0;
    logic       e_hit = 1'b0, e_title = 1'b1, e_rr = 1'b1;

    // Game model: whole-frame counts rather than saturating counters.
    int m_mode = 0;
    bit m_prev_start = 1'b1;
    bit m_pend = 1'b0;
    int m_frames = 0, m_since = 0, m_hold = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_prev_start = 1'b1; m_pend = 1'b0;
        m_frames = 0; m_since = 0; m_hold = 0;
    endfunction

    function automatic void model_step(bit st, bit nf, bit vis, bit dn, bit bd, bit ct,
                                       logic [15:0] rnd);
        bit rise, ov, sc, b, c, lf, rr;
        rise = st && !m_prev_start;
        m_prev_start = st;
        sc = 0; b = 0; c = 0; lf = 0; rr = 1;
`ifdef GAME_SEQ_GODMODE_EN
        ov = 1'b0;
`else
        ov = vis && dn && (bd || ct);
`endif
        case (m_mode)
            0: if (rise) begin
                m_mode = 1; m_frames = 0; m_since = 0; m_pend = 0; rr = 0;
            end
            1: begin
                if (nf) begin
                    if (m_pend || ov) begin
                        m_mode = 2; m_hold = 0;
                    end else begin
                        m_frames++;
                        lf = 1;
                        sc = (m_frames % SCORE_DIV) == 0;
                        if (m_since >= MIN_GAP && rnd[12:7] == 6'b101010) begin
                            c = 1; m_since = 0;
                        end else if (m_since >= MIN_GAP && rnd[12:8] == 5'd0) begin
                            b = 1; m_since = 0;
                        end else begin
                            m_since++;
                        end
                    end
                    m_pend = 0;
                end else if (ov) begin
                    m_pend = 1;
                end
            end
            default: begin
                if (rise && m_hold >= HIT_HOLD) m_mode = 0;
                else if (nf) m_hold++;
            end
        endcase
        if (m_mode == 0) lf = 1;
        e_state = 2'(m_mode);
        e_hit   = (m_mode == 2);
        e_title = (m_mode == 0);
        e_rr    = rr;
        if (sc || b || c || lf) exp_q.push_back('{cyc + 1, sc, b, c, lf});
    endfunction

    function automatic logic [3:0] safe_pix();
        logic [3:0] p;
        p = 4'($urandom);
        if (p[3] && p[2] && (p[1] || p[0])) p[3] = 1'b0;
        return p;
    endfunction

    function automatic logic [15:0] pick_rand();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom % 4)
            0: r = 16'h1500;
            1: r[12:8] = 5'd0;
            default: ;
        endcase
        return r;
    endfunction

    task automatic drive(input bit st, input bit nf, input bit vis, input bit dn, input bit bd,
                         input bit ct, input logic [15:0] rnd);
        @(negedge clk_i);
        if (!rst_ni) begin
            rst_ni = 1'b1;
            model_reset();
            mon_en = 1'b1;
        end
        start_i = st; next_frame_i = nf; visible_i = vis; dino_pixel_i = dn;
        bird_pixel_i = bd; cactus_pixel_i = ct; rand_i = rnd;
        if (nf) fr++;
        model_step(st, nf, vis, dn, bd, ct, rnd);
    endtask

    task automatic idle();
        logic [3:0] p;
        p = safe_pix();
        drive(st_lvl, 1'b0, p[3], p[2], p[1], p[0], 16'($urandom));
    endtask

    task automatic frame(input logic [15:0] rnd);
        logic [3:0] p;
        p = safe_pix();
        drive(st_lvl, 1'b1, p[3], p[2], p[1], p[0], rnd);
        repeat ($urandom_range(2, 4)) idle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_title"}, title_en_o, 1);
        check({tag, "_round_rst_n"}, round_rst_no, 1);
        check({tag, "_hit"}, hit_o, 0);
        check({tag, "_lfsr"}, lfsr_next_o, 0);
        check({tag, "_score"}, score_en_o, 0);
        check({tag, "_bird"}, bird_spawn_o, 0);
        check({tag, "_cactus"}, cactus_spawn_o, 0);
    endtask

    logic [3:0] mon_act;
    ev_t        mon_e;
    always @(posedge clk_i) begin
        #1;
        cyc++;
        if (mon_en) begin
            mon_act = {score_en_o, bird_spawn_o, cactus_spawn_o, lfsr_next_o};
            if (score_en_o) n_score++;
            if (bird_spawn_o) n_bird++;
            if (cactus_spawn_o) begin
                n_cact++;
                cact_frames.push_back(fr);
            end
            if (mon_act != 4'd0) begin
                if (exp_q.size() == 0) begin
                    check("pulse_unexpected", mon_act, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pulse_cycle", cyc, mon_e.due);
                    check("pulse_kind", mon_act, {mon_e.sc, mon_e.bd, mon_e.ct, mon_e.lf});
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                check("pulse_missing", mon_act, {mon_e.sc, mon_e.bd, mon_e.ct, mon_e.lf});
            end
            check("levels", {state_o, hit_o, title_en_o, round_rst_no},
                  {e_state, e_hit, e_title, e_rr});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int  base_score, base_bird;
    bit  found;
    logic exp_bit;

    initial begin
        #12;
        check_reset_values("reset");

        // Held button across reset release must not start a game.
        st_lvl = 1'b1;
        repeat (100) idle();
        st_lvl = 1'b0;
        repeat (3) idle();
        st_lvl = 1'b1;
        idle();
        st_lvl = 1'b0;
        fr = 0;
        cact_frames.delete();
        base_score = n_score;
        base_bird  = n_bird;

        repeat (60) frame(16'h1500);
        check("score_after_60_frames", n_score - base_score, 10);
        repeat (30) frame(16'h1500);
        check("cactus_count_90_frames", cact_frames.size(), 2);
        if (cact_frames.size() == 2) begin
            check("cactus_first_frame", cact_frames[0], 41);
            check("cactus_second_frame", cact_frames[1], 82);
        end
        check("bird_never_with_1500", n_bird - base_bird, 0);

        // Random play, random button toggles, invisible overlaps only.
        for (int i = 0; i < 150; i++) begin
            st_lvl = 1'($urandom);
            frame(pick_rand());
        end
        st_lvl = 1'b0;
        idle();

        // One visible overlap mid-frame; HIT at the next frame pulse.
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1500);
        idle();
        frame(16'h1500);
`ifdef GAME_SEQ_GODMODE_EN
        exp_bit = 1'b0;
`else
        exp_bit = 1'b1;
`endif
        check("hit_after_overlap", hit_o, exp_bit);

        repeat (20) frame(pick_rand());
        st_lvl = 1'b1;
        idle();
        st_lvl = 1'b0;
        repeat (38) frame(pick_rand());
        frame(pick_rand());
        st_lvl = 1'b1;
        frame(pick_rand());
        st_lvl = 1'b0;
        idle();
        st_lvl = 1'b1;
        frame(pick_rand());
`ifdef GAME_SEQ_GODMODE_EN
        check("state_after_hold_press", state_o, 1);
`else
        check("state_after_hold_press", state_o, 0);
`endif

        // Start rise coinciding with a frame pulse in STARTING.
        repeat (3) idle();
        st_lvl = 1'b0;
        idle();
        st_lvl = 1'b1;
        frame(pick_rand());
        st_lvl = 1'b0;
        repeat (10) frame(pick_rand());
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1500);
        repeat (2) idle();
        repeat (60) frame(pick_rand());
        st_lvl = 1'b1;
        idle();
        st_lvl = 1'b0;
        idle();
        st_lvl = 1'b1;
        idle();
        st_lvl = 1'b0;

        // Asynchronous reset while a cactus spawn pulse is on the outputs.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1500);
            @(posedge clk_i);
            #2;
            if (cactus_spawn_o) begin
                found = 1'b1;
                mon_en = 1'b0;
                rst_ni = 1'b0;
                #1;
                check_reset_values("async_reset");
            end else begin
                repeat (2) idle();
            end
        end
        check("reset_spawn_seen", found, 1);
        exp_q.delete();
        repeat (3) @(negedge clk_i);

        st_lvl = 1'b1;
        repeat (5) idle();
        st_lvl = 1'b0;
        idle();
        st_lvl = 1'b1;
        idle();
        repeat (8) frame(pick_rand());

        @(posedge clk_i);
        #2;
        mon_en = 1'b0;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
